// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the random-word server: tap mask, lock-up value,
// FSM state encoding and the 27-bit XNOR next-state function.
package lfsr_pkg;

  localparam int          LFSR27_W      = 27;
  // Feedback taps 26, 4, 1, 0
  localparam logic [26:0] LFSR27_TAPS   = 27'h400_0013;
  localparam logic [26:0] LFSR27_LOCKUP = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    ACK  = 2'd2
  } state_t;

  function automatic logic [26:0] lfsr27_next(input logic [26:0] r);
    return {r[25:0], ~(^(r & LFSR27_TAPS))};
  endfunction

endpackage

// File: rtl/lfsr_rand_server_rr_arbiter.sv
// Combinational round-robin picker: searches upward from the requester after
// `last`, wrapping, and returns the winner as one-hot and as an index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            vld
);

  int            k;
  logic [IW-1:0] kk;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    k   = 0;
    kk  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      k  = (int'(last) + i) % NREQ;
      kk = k[IW-1:0];
      if (!vld && req[kk]) begin
        vld     = 1'b1;
        gnt[kk] = 1'b1;
        idx     = kk;
      end
    end
  end

endmodule

// File: rtl/lfsr_rand_server.sv
// Shares one 27-bit XNOR LFSR among NREQ requesters: round-robin grant, STEPS
// advances per grant, registered one-hot ack with the resulting word.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for any req; arbitrates from (last+1) mod NREQ
// STEP  | advancing the LFSR once per enabled cycle, cnt counts down to 0
// ACK   | registering ack[g] and dat=r, pointer moves to g
module lfsr_rand_server
  import lfsr_pkg::*;
#(
  parameter int             NREQ  = 4,
  parameter int             WID   = 27,
  parameter int             STEPS = 8,
  parameter logic [WID-1:0] SEED  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic            seed_ld,
  input  logic [WID-1:0]  seed,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] ack,
  output logic [WID-1:0]  dat,
  output logic            busy
);

  localparam int         IW       = $clog2(NREQ);
  localparam logic [7:0] CNT_LOAD = 8'(STEPS - 1);

  state_t          state, state_nx;
  logic [WID-1:0]  r, r_nx;
  logic [7:0]      cnt, cnt_nx;
  logic [IW-1:0]   g, g_nx;
  logic [NREQ-1:0] g_oh, g_oh_nx;
  logic [IW-1:0]   last, last_nx;
  logic [NREQ-1:0] ack_nx;
  logic [WID-1:0]  dat_nx;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_vld;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req  (req),
    .last (last),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .vld  (arb_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r     <= SEED;
      cnt   <= '0;
      g     <= '0;
      g_oh  <= '0;
      last  <= IW'(NREQ - 1);
      ack   <= '0;
      dat   <= '0;
    end else if (ce) begin
      state <= state_nx;
      r     <= r_nx;
      cnt   <= cnt_nx;
      g     <= g_nx;
      g_oh  <= g_oh_nx;
      last  <= last_nx;
      ack   <= ack_nx;
      dat   <= dat_nx;
    end else begin
      // ack is a strobe: it must not stretch while the block is stalled
      ack <= '0;
    end
  end

  always_comb begin
    state_nx = state;
    r_nx     = r;
    cnt_nx   = cnt;
    g_nx     = g;
    g_oh_nx  = g_oh;
    last_nx  = last;
    ack_nx   = '0;
    dat_nx   = dat;

    if (seed_ld) begin
      // The lock-up pattern would stall the LFSR forever, so it loads as zero
      r_nx     = (seed == LFSR27_LOCKUP) ? '0 : seed;
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (arb_vld) begin
            g_nx     = arb_idx;
            g_oh_nx  = arb_gnt;
            cnt_nx   = CNT_LOAD;
            state_nx = STEP;
          end
        end
        STEP: begin
          r_nx = lfsr27_next(r);
          if (cnt == '0) begin
            state_nx = ACK;
          end else begin
            cnt_nx = cnt - 8'd1;
          end
        end
        ACK: begin
          ack_nx   = g_oh;
          dat_nx   = r;
          last_nx  = g;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_lfsr_rand_server.sv
// Self-checking bench for lfsr_rand_server: directed corner sequences, an
// arbitration vector table and randomized traffic against a transaction model.
module tb_lfsr_rand_server;

  localparam int NREQ  = 4;
  localparam int WID   = 27;
  localparam int STEPS = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            ce;
  logic            seed_ld;
  logic [WID-1:0]  seed;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] ack;
  logic [WID-1:0]  dat;
  logic            busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [WID-1:0] m_r;
  int             m_last;

  typedef struct {
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] exp_ack;
  } vec_t;

  vec_t vt[8];

  lfsr_rand_server #(
    .NREQ  (NREQ),
    .WID   (WID),
    .STEPS (STEPS),
    .SEED  ('0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .seed_ld (seed_ld),
    .seed    (seed),
    .req     (req),
    .ack     (ack),
    .dat     (dat),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One grant's worth of LFSR advances, from the parity rule on taps 26,4,1,0
  function automatic logic [WID-1:0] ref_adv(input logic [WID-1:0] v);
    logic [WID-1:0] x;
    x = v;
    for (int s = 0; s < STEPS; s++) begin
      int ones;
      int fb;
      ones = int'(x[26]) + int'(x[4]) + int'(x[1]) + int'(x[0]);
      fb   = (ones % 2 == 0) ? 1 : 0;
      x    = (x << 1) | WID'(fb);
    end
    return x;
  endfunction

  function automatic int ref_pick(input logic [NREQ-1:0] m, input int last);
    for (int i = 1; i <= NREQ; i++) begin
      if (m[(last + i) % NREQ]) return (last + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst     = 1'b1;
    req     = '0;
    seed_ld = 1'b0;
    seed    = '0;
    ce      = 1'b1;
    tick;
    tick;
    rst    = 1'b0;
    m_r    = '0;
    m_last = NREQ - 1;
  endtask

  // mode 0: ce held high, 1: ce toggles each cycle, 2: ce random (mostly high)
  task automatic wait_ack(input int mode, output int lat, output int nbusy,
                          output logic [NREQ-1:0] a, output logic [WID-1:0] d);
    lat   = 0;
    nbusy = 0;
    a     = '0;
    d     = '0;
    for (int c = 0; c < 400; c++) begin
      tick;
      lat++;
      if (busy) nbusy++;
      if (ack != '0) begin
        a = ack;
        d = dat;
        return;
      end
      if (mode == 1) ce = ~ce;
      else if (mode == 2) ce = ($urandom_range(0, 3) != 0);
    end
    n_chk++;
    n_fail++;
    $display("FAIL ack_timeout: no ack within %0d cycles", 400);
  endtask

  initial begin
    int              lat;
    int              nb;
    int              w;
    logic [NREQ-1:0] a;
    logic [NREQ-1:0] m;
    logic [WID-1:0]  d;
    logic [WID-1:0]  e;

    vt[0] = '{4'b0101, 4'b0001};
    vt[1] = '{4'b0101, 4'b0100};
    vt[2] = '{4'b0101, 4'b0001};
    vt[3] = '{4'b1000, 4'b1000};
    vt[4] = '{4'b0011, 4'b0001};
    vt[5] = '{4'b1110, 4'b0010};
    vt[6] = '{4'b1100, 4'b0100};
    vt[7] = '{4'b1001, 4'b1000};

    // Reset state and the basic single-requester grant
    do_reset;
    chk("rst_ack", ack, 0);
    chk("rst_dat", dat, 0);
    chk("rst_busy", busy, 0);
    req = 4'b0001;
    wait_ack(0, lat, nb, a, d);
    req = '0;
    chk("t1_latency", lat - 1, STEPS + 1);
    chk("t1_busy_cycles", nb, STEPS + 1);
    chk("t1_ack", a, 4'b0001);
    chk("t1_dat", d, 27'h94);
    tick;
    chk("t1_ack_clears", ack, 0);
    chk("t1_dat_holds", dat, 27'h94);
    chk("t1_idle", busy, 0);

    // Arbitration table from reset
    do_reset;
    for (int i = 0; i < 8; i++) begin
      req = vt[i].req;
      wait_ack(0, lat, nb, a, d);
      req = '0;
      m_r = ref_adv(m_r);
      chk($sformatf("vec%0d_ack", i), a, vt[i].exp_ack);
      chk($sformatf("vec%0d_dat", i), d, m_r);
      chk($sformatf("vec%0d_lat", i), lat - 1, STEPS + 1);
    end

    // All requesters held: strict rotation, one grant per STEPS+2 cycles
    do_reset;
    req = '1;
    for (int k = 0; k < 5; k++) begin
      wait_ack(0, lat, nb, a, d);
      m_r = ref_adv(m_r);
      chk($sformatf("rr%0d_ack", k), a, NREQ'(1) << (k % NREQ));
      chk($sformatf("rr%0d_dat", k), d, m_r);
      chk($sformatf("rr%0d_period", k), lat, STEPS + 2);
    end
    req = '0;

    // All-ones seed loads as zero
    seed_ld = 1'b1;
    seed    = '1;
    tick;
    seed_ld = 1'b0;
    chk("seed1_idle", busy, 0);
    req = 4'b0100;
    wait_ack(0, lat, nb, a, d);
    req = '0;
    chk("seed1_ack", a, 4'b0100);
    chk("seed1_dat", d, ref_adv('0));
    chk("seed1_lat", lat - 1, STEPS + 1);

    // Seed load mid-transaction aborts, held request is re-granted
    req = 4'b0010;
    tick;
    tick;
    tick;
    tick;
    chk("abort_busy_before", busy, 1);
    seed_ld = 1'b1;
    seed    = 27'h123_4567;
    tick;
    seed_ld = 1'b0;
    chk("abort_no_ack", ack, 0);
    chk("abort_busy_drop", busy, 0);
    wait_ack(0, lat, nb, a, d);
    req = '0;
    chk("abort_regrant_ack", a, 4'b0010);
    chk("abort_regrant_dat", d, ref_adv(27'h123_4567));
    chk("abort_regrant_lat", lat - 1, STEPS + 1);

    // ce toggling every cycle doubles latency without changing the word
    do_reset;
    req = 4'b0001;
    wait_ack(1, lat, nb, a, d);
    ce  = 1'b1;
    req = '0;
    chk("ce_latency", lat - 1, 2 * (STEPS + 1));
    chk("ce_ack", a, 4'b0001);
    chk("ce_dat", d, 27'h94);

    // rst in the middle of STEP
    do_reset;
    req = 4'b0001;
    tick;
    for (int i = 0; i < 5; i++) tick;
    rst = 1'b1;
    tick;
    chk("midrst_ack", ack, 0);
    chk("midrst_dat", dat, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    wait_ack(0, lat, nb, a, d);
    req = '0;
    chk("midrst_ack_after", a, 4'b0001);
    chk("midrst_dat_after", d, 27'h94);
    chk("midrst_lat_after", lat - 1, STEPS + 1);

    // Randomized traffic against the transaction-level model
    do_reset;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        seed_ld = 1'b1;
        ce      = 1'b1;
        seed    = ($urandom_range(0, 3) == 0) ? '1 : WID'($urandom);
        tick;
        seed_ld = 1'b0;
        m_r     = (seed == '1) ? '0 : seed;
      end
      m   = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      req = m;
      ce  = 1'b1;
      wait_ack(2, lat, nb, a, d);
      req = '0;
      ce  = 1'b1;
      w   = ref_pick(m, m_last);
      m_last = w;
      m_r = ref_adv(m_r);
      chk($sformatf("rnd%0d_ack", t), a, NREQ'(1) << w);
      chk($sformatf("rnd%0d_dat", t), d, m_r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
